// File: rtl/vga_sync_gen.sv
// 640x480@60 pixel-timing generator: pixel-rate divider, x/y raster counters,
// registered active-low sync pulses and decoded video_on/line/frame strobes.
module vga_sync_gen #(
    parameter int DIV       = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST     = 4'(DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_END   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_END   = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [3:0] div_cnt_reg;
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;
    logic       hsync_reg, vsync_reg;

    // With DIV = 1 the counter sits at 0 == DIV_LAST, so p_tick stays high.
    assign p_tick = (div_cnt_reg == DIV_LAST);

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (p_tick) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                if (y_reg == V_LAST) begin
                    y_next = '0;
                end else begin
                    y_next = y_reg + 10'd1;
                end
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next-state counters so they switch on the
    // same edge as x/y rather than one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
        end else begin
            div_cnt_reg <= p_tick ? 4'd0 : div_cnt_reg + 4'd1;
            x_reg       <= x_next;
            y_reg       <= y_next;
            hsync_reg   <= !((x_next >= H_SYNC_START) && (x_next <= H_SYNC_END));
            vsync_reg   <= !((y_next >= V_SYNC_START) && (y_next <= V_SYNC_END));
        end
    end

    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign x          = x_reg;
    assign y          = y_reg;
    assign video_on   = (x_reg < H_DISP_END) && (y_reg < V_DISP_END);
    assign line_tick  = p_tick && (x_reg == H_LAST);
    assign frame_tick = line_tick && (y_reg == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-timing DIV=4 line checks, a shortened-frame
// DIV=4 instance for frame/refresh/mid-frame reset, and a DIV=1 instance.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int x;
        int y;
        bit hs;
        bit vs;
        bit von;
        bit pt;
        bit lt;
        bit ft;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // full-timing instance, DIV = 4
    logic       f_reset;
    logic       f_hsync, f_vsync, f_video_on, f_p_tick, f_line_tick, f_frame_tick;
    logic [9:0] f_x, f_y;
    // shortened frame (7 lines), DIV = 4
    logic       s_reset;
    logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_line_tick, s_frame_tick;
    logic [9:0] s_x, s_y;
    // shortened frame (7 lines), DIV = 1
    logic       o_reset;
    logic       o_hsync, o_vsync, o_video_on, o_p_tick, o_line_tick, o_frame_tick;
    logic [9:0] o_x, o_y;

    vga_sync_gen u_full (
        .clk(clk), .reset(f_reset), .hsync(f_hsync), .vsync(f_vsync),
        .video_on(f_video_on), .p_tick(f_p_tick), .x(f_x), .y(f_y),
        .line_tick(f_line_tick), .frame_tick(f_frame_tick)
    );

    vga_sync_gen #(.DIV(4), .V_DISPLAY(3), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_small (
        .clk(clk), .reset(s_reset), .hsync(s_hsync), .vsync(s_vsync),
        .video_on(s_video_on), .p_tick(s_p_tick), .x(s_x), .y(s_y),
        .line_tick(s_line_tick), .frame_tick(s_frame_tick)
    );

    vga_sync_gen #(.DIV(1), .V_DISPLAY(3), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_one (
        .clk(clk), .reset(o_reset), .hsync(o_hsync), .vsync(o_vsync),
        .video_on(o_video_on), .p_tick(o_p_tick), .x(o_x), .y(o_y),
        .line_tick(o_line_tick), .frame_tick(o_frame_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v,
                             input logic [9:0] ax, input logic [9:0] ay,
                             input logic ahs, input logic avs, input logic avon,
                             input logic apt, input logic alt, input logic aft);
        string n;
        n = $sformatf("%s k=%0d", tag, v.k);
        cmp({n, " x"}, 32'(ax), v.x);
        cmp({n, " y"}, 32'(ay), v.y);
        cmp({n, " hsync"}, 32'(ahs), 32'(v.hs));
        cmp({n, " vsync"}, 32'(avs), 32'(v.vs));
        cmp({n, " video_on"}, 32'(avon), 32'(v.von));
        cmp({n, " p_tick"}, 32'(apt), 32'(v.pt));
        cmp({n, " line_tick"}, 32'(alt), 32'(v.lt));
        cmp({n, " frame_tick"}, 32'(aft), 32'(v.ft));
        $display("%s: x=%0d y=%0d hs=%0b vs=%0b von=%0b pt=%0b lt=%0b ft=%0b",
                 n, ax, ay, ahs, avs, avon, apt, alt, aft);
    endtask

    vec_t tf[11];
    vec_t to[13];

    initial begin
        int k;
        int hs_low, von_low, lt_cnt;
        int vs_low, ft_cnt, ft_k, lt_s, ref_cnt, ref_von, ft_no_lt;

        //         k     x    y  hs vs von pt lt ft
        tf[0]  = '{0,    0,   0, 1, 1, 1, 0, 0, 0};
        tf[1]  = '{3,    0,   0, 1, 1, 1, 1, 0, 0};
        tf[2]  = '{4,    1,   0, 1, 1, 1, 0, 0, 0};
        tf[3]  = '{2559, 639, 0, 1, 1, 1, 1, 0, 0};
        tf[4]  = '{2560, 640, 0, 1, 1, 0, 0, 0, 0};
        tf[5]  = '{2623, 655, 0, 1, 1, 0, 1, 0, 0};
        tf[6]  = '{2624, 656, 0, 0, 1, 0, 0, 0, 0};
        tf[7]  = '{3007, 751, 0, 0, 1, 0, 1, 0, 0};
        tf[8]  = '{3008, 752, 0, 1, 1, 0, 0, 0, 0};
        tf[9]  = '{3199, 799, 0, 1, 1, 0, 1, 1, 0};
        tf[10] = '{3200, 0,   1, 1, 1, 1, 0, 0, 0};

        to[0]  = '{0,    0,   0, 1, 1, 1, 1, 0, 0};
        to[1]  = '{1,    1,   0, 1, 1, 1, 1, 0, 0};
        to[2]  = '{639,  639, 0, 1, 1, 1, 1, 0, 0};
        to[3]  = '{640,  640, 0, 1, 1, 0, 1, 0, 0};
        to[4]  = '{656,  656, 0, 0, 1, 0, 1, 0, 0};
        to[5]  = '{752,  752, 0, 1, 1, 0, 1, 0, 0};
        to[6]  = '{799,  799, 0, 1, 1, 0, 1, 1, 0};
        to[7]  = '{800,  0,   1, 1, 1, 1, 1, 0, 0};
        to[8]  = '{2400, 0,   3, 1, 1, 0, 1, 0, 0};
        to[9]  = '{3200, 0,   4, 1, 0, 0, 1, 0, 0};
        to[10] = '{4800, 0,   6, 1, 1, 0, 1, 0, 0};
        to[11] = '{5599, 799, 6, 1, 1, 0, 1, 1, 1};
        to[12] = '{5600, 0,   0, 1, 1, 1, 1, 0, 0};

        f_reset = 1'b1;
        s_reset = 1'b1;
        o_reset = 1'b1;
        repeat (3) step();

        // ---- full timing, one line ----
        f_reset = 1'b0;
        k = 0;
        hs_low = 0;
        von_low = 0;
        lt_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            while (k < tf[i].k) begin
                step();
                k++;
                if (!f_hsync) hs_low++;
                if (!f_video_on) von_low++;
                if (f_line_tick) lt_cnt++;
            end
            check_vec("full", tf[i], f_x, f_y, f_hsync, f_vsync, f_video_on,
                      f_p_tick, f_line_tick, f_frame_tick);
        end
        cmp("full hsync low clocks", hs_low, 384);
        cmp("full video_off clocks", von_low, 640);
        cmp("full line_tick count", lt_cnt, 1);
        $display("full line: hsync_low=%0d video_off=%0d line_ticks=%0d", hs_low, von_low, lt_cnt);

        // ---- shortened frame at DIV = 4 ----
        s_reset = 1'b0;
        vs_low = 0;
        ft_cnt = 0;
        ft_k = -1;
        lt_s = 0;
        ref_cnt = 0;
        ref_von = 0;
        ft_no_lt = 0;
        for (int j = 1; j <= 22400; j++) begin
            step();
            if (!s_vsync) vs_low++;
            if (s_line_tick) lt_s++;
            if (s_frame_tick) begin
                ft_cnt++;
                ft_k = j;
                if (!s_line_tick) ft_no_lt++;
            end
            if (s_y == 10'd4 && s_x == 10'd0) begin
                ref_cnt++;
                if (s_video_on) ref_von++;
            end
        end
        cmp("frame vsync low clocks", vs_low, 6400);
        cmp("frame frame_tick count", ft_cnt, 1);
        cmp("frame frame_tick cycle", ft_k, 22399);
        cmp("frame frame_tick without line_tick", ft_no_lt, 0);
        cmp("frame line_tick count", lt_s, 7);
        cmp("frame refresh point clocks", ref_cnt, 4);
        cmp("frame refresh video_on high", ref_von, 0);
        cmp("frame restart x", 32'(s_x), 0);
        cmp("frame restart y", 32'(s_y), 0);
        $display("frame: vsync_low=%0d frame_ticks=%0d at k=%0d line_ticks=%0d refresh=%0d",
                 vs_low, ft_cnt, ft_k, lt_s, ref_cnt);

        // ---- reset mid-frame at x=300, y=2, div_cnt=2 ----
        repeat (7602) step();
        cmp("midreset pre x", 32'(s_x), 300);
        cmp("midreset pre y", 32'(s_y), 2);
        cmp("midreset pre p_tick", 32'(s_p_tick), 0);
        s_reset = 1'b1;
        step();
        cmp("midreset x", 32'(s_x), 0);
        cmp("midreset y", 32'(s_y), 0);
        cmp("midreset hsync", 32'(s_hsync), 1);
        cmp("midreset vsync", 32'(s_vsync), 1);
        cmp("midreset p_tick", 32'(s_p_tick), 0);
        s_reset = 1'b0;
        step();
        cmp("midreset p_tick +1", 32'(s_p_tick), 0);
        step();
        cmp("midreset p_tick +2", 32'(s_p_tick), 0);
        step();
        cmp("midreset p_tick +3", 32'(s_p_tick), 1);
        cmp("midreset x +3", 32'(s_x), 0);
        step();
        cmp("midreset x +4", 32'(s_x), 1);
        $display("midframe reset: x=%0d y=%0d after restart", s_x, s_y);

        // ---- DIV = 1 ----
        o_reset = 1'b0;
        k = 0;
        for (int i = 0; i < 13; i++) begin
            while (k < to[i].k) begin
                step();
                k++;
            end
            check_vec("div1", to[i], o_x, o_y, o_hsync, o_vsync, o_video_on,
                      o_p_tick, o_line_tick, o_frame_tick);
        end

        // reset must win over the always-high p_tick
        repeat (10) step();
        cmp("div1 pre-reset x", 32'(o_x), 10);
        o_reset = 1'b1;
        step();
        cmp("div1 reset dominates x", 32'(o_x), 0);
        cmp("div1 reset dominates y", 32'(o_y), 0);
        o_reset = 1'b0;
        step();
        cmp("div1 post-reset x", 32'(o_x), 1);
        $display("div1 reset dominance: x=%0d y=%0d", o_x, o_y);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
